// File: rtl/encoded_request_decoder.sv
// Decodes the active-low 8:3 priority-encoder code into sticky pending requests
// and services them one at a time, highest index first, as timed active-low strobes.
module encoded_request_decoder #(
   parameter int PULSE_CYCLES = 4,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] y_n,
   input  logic       gs_n,
   input  logic       en_n,
   output logic [7:0] d_n,
   output logic       busy,
   output logic       ack,
   output logic [7:0] pending
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PULSE = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   logic [2:0]       y_s1, y_s2;
   logic             gs_s1, gs_s2;
   logic [1:0]       state;
   logic [2:0]       idx;
   logic [2:0]       top_idx;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       cap_set, svc_clr, abort_set, pend_nxt;
   logic             start;

   // Synchronizer resets to the "no request" code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_s1  <= 3'b111;
         y_s2  <= 3'b111;
         gs_s1 <= 1'b1;
         gs_s2 <= 1'b1;
      end else begin
         y_s1  <= y_n;
         y_s2  <= y_s1;
         gs_s1 <= gs_n;
         gs_s2 <= gs_s1;
      end
   end

   always_comb begin
      cap_set = '0;
      if (!gs_s2) cap_set[~y_s2] = 1'b1;
   end

   always_comb begin
      top_idx = '0;
      for (int i = 0; i < 8; i++)
         if (pending[i]) top_idx = 3'(i);
   end

   assign start = (state == IDLE) && !en_n && (pending != '0);

   always_comb begin
      svc_clr   = '0;
      abort_set = '0;
      if (start) svc_clr[top_idx] = 1'b1;
      if (state == PULSE && en_n) abort_set[idx] = 1'b1;
   end

   // Capture is OR'd last so a same-cycle re-request survives the service clear.
   assign pend_nxt = (pending & ~svc_clr) | abort_set | cap_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         d_n     <= 8'hFF;
         busy    <= 1'b0;
         ack     <= 1'b0;
         pending <= '0;
      end else begin
         pending <= pend_nxt;
         ack     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx   <= top_idx;
                  cnt   <= CNT_W'(PULSE_CYCLES - 1);
                  d_n   <= ~(8'h01 << top_idx);
                  busy  <= 1'b1;
                  state <= PULSE;
               end
            end
            PULSE: begin
               if (en_n) begin
                  d_n   <= 8'hFF;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (cnt == '0) begin
                  d_n   <= 8'hFF;
                  ack   <= 1'b1;
                  state <= GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            GAP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               d_n   <= 8'hFF;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoded_request_decoder.sv
// Randomized bench for encoded_request_decoder: two instances (PULSE_CYCLES 4 and 1)
// against a service-timeline model, plus directed scenarios with literal expectations.
module tb_encoded_request_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] y_n = 3'b111;
   logic       gs_n = 1'b1;
   logic       en_n = 1'b1;
   logic [7:0] d_n [2];
   logic       busy [2];
   logic       ack [2];
   logic [7:0] pending [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   encoded_request_decoder #(.PULSE_CYCLES(4), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .y_n(y_n), .gs_n(gs_n), .en_n(en_n),
      .d_n(d_n[0]), .busy(busy[0]), .ack(ack[0]), .pending(pending[0]));

   encoded_request_decoder #(.PULSE_CYCLES(1), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .y_n(y_n), .gs_n(gs_n), .en_n(en_n),
      .d_n(d_n[1]), .busy(busy[1]), .ack(ack[1]), .pending(pending[1]));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each service is a timeline t = 0..P-1 strobe low, t = P gap with ack.
   int mp   [2] = '{4, 1};
   int mpend[2];
   int midx [2];
   int mt   [2];
   int my1, my2, mg1, mg2;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mpend[k] = 0;
         midx[k]  = -1;
         mt[k]    = 0;
      end
      my1 = 7; my2 = 7; mg1 = 1; mg2 = 1;
   endtask

   task automatic model_step(input int k, input int cap);
      int b;
      if (midx[k] < 0) begin
         if (!en_n && mpend[k] != 0) begin
            b = 0;
            for (int i = 0; i < 8; i++) if (mpend[k][i]) b = i;
            mpend[k] = mpend[k] & ~(1 << b);
            midx[k] = b;
            mt[k] = 0;
         end
      end else if (mt[k] < mp[k]) begin
         if (en_n) begin
            mpend[k] = mpend[k] | (1 << midx[k]);
            midx[k] = -1;
         end else begin
            mt[k] = mt[k] + 1;
         end
      end else begin
         midx[k] = -1;
      end
      mpend[k] = mpend[k] | cap;
   endtask

   always begin
      int cap;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         cap = (mg2 == 0) ? (1 << (7 - my2)) : 0;
         model_step(0, cap);
         model_step(1, cap);
         my2 = my1; mg2 = mg1;
         my1 = int'(y_n); mg1 = int'(gs_n);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         int ed;
         ed = (midx[k] >= 0 && mt[k] < mp[k]) ? (8'hFF & ~(1 << midx[k])) : 8'hFF;
         chk($sformatf("u%0d.d_n", k), int'(d_n[k]), ed);
         chk($sformatf("u%0d.busy", k), int'(busy[k]), (midx[k] >= 0) ? 1 : 0);
         chk($sformatf("u%0d.ack", k), int'(ack[k]), (midx[k] >= 0 && mt[k] == mp[k]) ? 1 : 0);
         chk($sformatf("u%0d.pending", k), int'(pending[k]), mpend[k]);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   initial begin
      bit hit;
      model_reset();
      // Reset with arbitrary inputs
      y_n = 3'b000; gs_n = 1'b0; en_n = 1'b0;
      tick(3);
      chk("rst d_n", int'(d_n[0]), 8'hFF);
      chk("rst pending", int'(pending[0]), 0);
      chk("rst busy", int'(busy[0]), 0);
      gs_n = 1'b1; y_n = 3'b111; en_n = 1'b1;
      tick(1);
      rst_n = 1'b1;
      tick(3);
      chk("idle d_n", int'(d_n[0]), 8'hFF);
      chk("idle pending", int'(pending[0]), 0);

      // Single request, index 7
      en_n = 1'b0; y_n = 3'b000; gs_n = 1'b0;
      tick(1);                       // E
      gs_n = 1'b1; y_n = 3'b111;
      tick(2);                       // E+2
      chk("single pending E+2", int'(pending[0]), 8'h80);
      chk("single d_n E+2", int'(d_n[0]), 8'hFF);
      tick(1);                       // E+3
      chk("single d_n E+3", int'(d_n[0]), 8'h7F);
      tick(3);                       // E+6
      chk("single d_n E+6", int'(d_n[0]), 8'h7F);
      chk("single ack E+6", int'(ack[0]), 0);
      tick(1);                       // E+7
      chk("single d_n E+7", int'(d_n[0]), 8'hFF);
      chk("single ack E+7", int'(ack[0]), 1);
      tick(1);
      chk("single busy E+8", int'(busy[0]), 0);
      chk("single pending E+8", int'(pending[0]), 0);
      tick(3);

      // Priority: index 0 then index 2 captured while disabled
      en_n = 1'b1; gs_n = 1'b0; y_n = 3'b111;
      tick(1);
      y_n = 3'b101;
      tick(1);
      gs_n = 1'b1; y_n = 3'b111;
      tick(4);
      chk("prio pending", int'(pending[0]), 8'h05);
      chk("prio d_n disabled", int'(d_n[0]), 8'hFF);
      en_n = 1'b0;
      tick(1);
      chk("prio first d_n", int'(d_n[0]), 8'hFB);
      tick(25);

      // Abort of index 3 after two strobe cycles
      y_n = 3'b100; gs_n = 1'b0;
      tick(1);
      gs_n = 1'b1; y_n = 3'b111;
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         tick(1);
         if (d_n[0] == 8'hF7) hit = 1'b1;
      end
      chk("abort strobe seen", int'(hit), 1);
      tick(1);
      en_n = 1'b1;
      tick(1);
      chk("abort d_n", int'(d_n[0]), 8'hFF);
      chk("abort ack", int'(ack[0]), 0);
      chk("abort pending", int'(pending[0]), 8'h08);
      tick(3);
      en_n = 1'b0;
      tick(20);

      // Continuous re-capture of index 5
      y_n = 3'b010; gs_n = 1'b0;
      tick(40);
      gs_n = 1'b1; y_n = 3'b111;
      tick(20);

      // Random traffic with occasional disable and reset
      for (int c = 0; c < 3000; c++) begin
         y_n  = 3'($urandom_range(0, 7));
         gs_n = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
         en_n = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
         rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      rst_n = 1'b1; gs_n = 1'b1; en_n = 1'b0;
      tick(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
